keypad_bank_writer: RTL

KEYPAD_BANK_WRITER -- requirements
Module: keypad_bank_writer

---
 rtl/keypad_bank_writer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/keypad_bank_writer.sv
// Keypad-driven register-bank writer: an address key, then a color key, produces one bank write.
// Key 15 from idle sweeps the whole bank to color 0.
module keypad_bank_writer #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 3,
    parameter int TIMEOUT = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic [ADDR_W-1:0] addrW,
    output logic [DATA_W-1:0] datW,
    output logic              RegWrite,
    output logic              pending,
    output logic              busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] SWEEP_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_GOT_ADDR, S_WRITE, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic              key_prev_q;
    logic              key_event_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addrw_q, addrw_d;
    logic [DATA_W-1:0] datw_q, datw_d;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;

    assign key_event_s = key_valid & ~key_prev_q;

    // Next-state and next-output logic; outputs are computed from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        sweep_d = sweep_q;
        we_d    = 1'b0;
        addrw_d = addrw_q;
        datw_d  = datw_q;
        case (state_q)
            S_IDLE: begin
                if (key_event_s) begin
                    if (key_code == 4'd15) begin
                        sweep_d = {ADDR_W{1'b0}};
                        state_d = S_CLEAR;
                        we_d    = 1'b1;
                        addrw_d = {ADDR_W{1'b0}};
                        datw_d  = {DATA_W{1'b0}};
                    end else begin
                        addr_d  = ADDR_W'(key_code);
                        timer_d = {TW{1'b0}};
                        state_d = S_GOT_ADDR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GOT_ADDR: begin
                // A key event takes priority over an expiring timer.
                if (key_event_s) begin
                    if (key_code < 4'd8) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addrw_d = addr_q;
                        datw_d  = DATA_W'(key_code[2:0]);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = {TW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (sweep_q == SWEEP_LAST) begin
                    sweep_d = {ADDR_W{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    sweep_d = sweep_q + ADDR_W'(1'b1);
                    we_d    = 1'b1;
                    addrw_d = sweep_q + ADDR_W'(1'b1);
                    datw_d  = {DATA_W{1'b0}};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pending_d = (state_d == S_GOT_ADDR);
        busy_d    = (state_d == S_WRITE) || (state_d == S_CLEAR);
    end

    // State, datapath and output registers; key_prev resets high so a held key cannot fire on release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            key_prev_q <= 1'b1;
            addr_q     <= {ADDR_W{1'b0}};
            timer_q    <= {TW{1'b0}};
            sweep_q    <= {ADDR_W{1'b0}};
            we_q       <= 1'b0;
            addrw_q    <= {ADDR_W{1'b0}};
            datw_q     <= {DATA_W{1'b0}};
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_valid;
            addr_q     <= addr_d;
            timer_q    <= timer_d;
            sweep_q    <= sweep_d;
            we_q       <= we_d;
            addrw_q    <= addrw_d;
            datw_q     <= datw_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
        end
    end

    assign RegWrite = we_q;
    assign addrW    = addrw_q;
    assign datW     = datw_q;
    assign pending  = pending_q;
    assign busy     = busy_q;

endmodule
